// File: rtl/xilinx_fpga_ram_pkg.sv
// xilinx_fpga_ram_pkg: shared write-mode constants and clear-FSM state encoding
package xilinx_fpga_ram_pkg;
  localparam int MODE_WF = 0;
  localparam int MODE_RF = 1;
  localparam int MODE_NC = 2;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
endpackage

// File: rtl/xilinx_fpga_ram_lane.sv
// xilinx_fpga_ram_lane: one 8-bit true-dual-port BRAM lane with registered read data
module xilinx_fpga_ram_lane import xilinx_fpga_ram_pkg::*; #(
  parameter int DEPTH = 10,
  parameter int MODE = MODE_WF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_a,
  input  logic             re_a,
  input  logic [DEPTH-1:0] addr_a,
  input  logic [7:0]       di_a,
  output logic [7:0]       q_a,
  input  logic             we_b,
  input  logic             re_b,
  input  logic [DEPTH-1:0] addr_b,
  input  logic [7:0]       di_b,
  output logic [7:0]       q_b
);
  logic [7:0] mem [2**DEPTH];
  // Port A is written last so it wins any same-address, same-lane write that slips through
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= di_b;
    if (we_a) mem[addr_a] <= di_a;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (re_a) q_a <= (MODE == MODE_WF && we_a) ? di_a : mem[addr_a];
      if (re_b) q_b <= (MODE == MODE_WF && we_b) ? di_b : mem[addr_b];
    end
endmodule

// File: rtl/xilinx_fpga_dpram_be.sv
// xilinx_fpga_dpram_be: byte-enabled true-dual-port RAM with write modes, optional output register and post-reset clear
module xilinx_fpga_dpram_be import xilinx_fpga_ram_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int MODE = 0,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_a,
  input  logic [WIDTH/8-1:0] we_a,
  input  logic [DEPTH-1:0]   addr_a,
  input  logic [WIDTH-1:0]   di_a,
  output logic [WIDTH-1:0]   dout_a,
  output logic               rvalid_a,
  input  logic               en_b,
  input  logic [WIDTH/8-1:0] we_b,
  input  logic [DEPTH-1:0]   addr_b,
  input  logic [WIDTH-1:0]   di_b,
  output logic [WIDTH-1:0]   dout_b,
  output logic               rvalid_b,
  output logic               init_busy
);
  localparam int NB = WIDTH / 8;
  localparam logic [DEPTH-1:0] LAST = '1;
  state_t state, state_nx;
  logic [DEPTH-1:0] cnt, cnt_nx, aa;
  logic busy, acc_a, acc_b, coll, v_a, v_b;
  logic [NB-1:0] wa, wb;
  logic [WIDTH-1:0] da, qa, qb;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = (busy && cnt == LAST) ? ST_READY : state;
    cnt_nx = busy ? cnt + 1'b1 : cnt;
  end
  assign busy = state == ST_CLEAR;
  assign init_busy = busy;
  assign acc_a = en_a & ~busy & ~(MODE == MODE_NC && |we_a);
  assign acc_b = en_b & ~busy & ~(MODE == MODE_NC && |we_b);
  assign coll = en_a & en_b & (addr_a == addr_b);
  // The clear engine borrows port A and writes zeros to every lane
  assign wa = busy ? '1 : {NB{en_a}} & we_a;
  assign aa = busy ? cnt : addr_a;
  assign da = busy ? '0 : di_a;
  assign wb = {NB{en_b & ~busy}} & we_b & ~({NB{coll}} & we_a);
  for (genvar i = 0; i < NB; i++) begin : g_lane
    xilinx_fpga_ram_lane #(.DEPTH(DEPTH), .MODE(MODE)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .we_a(wa[i]),
      .re_a(acc_a),
      .addr_a(aa),
      .di_a(da[8*i+:8]),
      .q_a(qa[8*i+:8]),
      .we_b(wb[i]),
      .re_b(acc_b),
      .addr_b(addr_b),
      .di_b(di_b[8*i+:8]),
      .q_b(qb[8*i+:8])
    );
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      v_a <= 1'b0;
      v_b <= 1'b0;
    end else begin
      v_a <= acc_a;
      v_b <= acc_b;
    end
  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] r_a, r_b;
    logic rv_a, rv_b;
    always_ff @(posedge clk)
      if (!rst_n) begin
        r_a <= '0;
        r_b <= '0;
        rv_a <= 1'b0;
        rv_b <= 1'b0;
      end else begin
        r_a <= qa;
        r_b <= qb;
        rv_a <= v_a;
        rv_b <= v_b;
      end
    assign dout_a = r_a;
    assign dout_b = r_b;
    assign rvalid_a = rv_a;
    assign rvalid_b = rv_b;
  end else begin : g_direct
    assign dout_a = qa;
    assign dout_b = qb;
    assign rvalid_a = v_a;
    assign rvalid_b = v_b;
  end
endmodule

// File: tb/tb_xilinx_fpga_dpram_be.sv
// tb_xilinx_fpga_dpram_be: three write-mode variants plus a no-clear variant driven in lockstep
module tb_xilinx_fpga_dpram_be;
  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b;
  logic [3:0] we_a, we_b, addr_a, addr_b;
  logic [31:0] di_a, di_b;
  logic [31:0] da [4];
  logic [31:0] db [4];
  logic va [4];
  logic vb [4];
  logic bz [4];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  xilinx_fpga_dpram_be #(.WIDTH(32), .DEPTH(4), .MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
    .dout_a(da[0]), .rvalid_a(va[0]), .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
    .dout_b(db[0]), .rvalid_b(vb[0]), .init_busy(bz[0]));
  xilinx_fpga_dpram_be #(.WIDTH(32), .DEPTH(4), .MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_rf (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
    .dout_a(da[1]), .rvalid_a(va[1]), .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
    .dout_b(db[1]), .rvalid_b(vb[1]), .init_busy(bz[1]));
  xilinx_fpga_dpram_be #(.WIDTH(32), .DEPTH(4), .MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_nc (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
    .dout_a(da[2]), .rvalid_a(va[2]), .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
    .dout_b(db[2]), .rvalid_b(vb[2]), .init_busy(bz[2]));
  xilinx_fpga_dpram_be #(.WIDTH(32), .DEPTH(4), .MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u_nr (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
    .dout_a(da[3]), .rvalid_a(va[3]), .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
    .dout_b(db[3]), .rvalid_b(vb[3]), .init_busy(bz[3]));

  typedef struct {
    logic en_a; logic [3:0] we_a, addr_a; logic [31:0] di_a;
    logic en_b; logic [3:0] we_b, addr_b; logic [31:0] di_b;
    logic [31:0] ea_wf, ea_rf, ea_nc;
    logic chk_b;
    logic [31:0] eb_wf, eb_rf, eb_nc;
  } vec_t;
  vec_t tv [13];

  logic [31:0] mm [16];
  logic [31:0] ed [3][2];
  logic ev [3][2];
  logic [31:0] s1 [3][2];
  logic v1 [3][2];
  int mode_of [3] = '{0, 1, 2};
  int oreg_of [3] = '{0, 1, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = '0; addr_a = '0; di_a = '0;
    en_b = 1'b0; we_b = '0; addr_b = '0; di_b = '0;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (bz[0] && n < 100) begin
      step();
      n++;
      chk({name, "_rvalid_a"}, {31'b0, va[0]}, 32'h0);
      chk({name, "_rvalid_b"}, {31'b0, vb[0]}, 32'h0);
    end
    chk({name, "_cycles"}, n, 16);
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 16; a++) begin
      en_a = 1'b1; we_a = '0; addr_a = 4'(a);
      step();
      chk($sformatf("%s_rd%0d", name, a), da[0], 32'h0);
      chk($sformatf("%s_rv%0d", name, a), {31'b0, va[0]}, 32'h1);
    end
    idle();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 1'b0, 4'h0, 4'd0,  32'h0,
               32'hAABBCCDD, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[1]  = '{1'b1, 4'h5, 4'd5,  32'h11223344, 1'b0, 4'h0, 4'd0,  32'h0,
               32'hAA22CC44, 32'hAABBCCDD, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[2]  = '{1'b1, 4'h0, 4'd5,  32'h0, 1'b0, 4'h0, 4'd0, 32'h0,
               32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[3]  = '{1'b1, 4'hF, 4'd7,  32'h1, 1'b0, 4'h0, 4'd0, 32'h0,
               32'h1, 32'h0, 32'hAA22CC44, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[4]  = '{1'b1, 4'hF, 4'd7,  32'h2, 1'b0, 4'h0, 4'd0, 32'h0,
               32'h2, 32'h1, 32'hAA22CC44, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[5]  = '{1'b1, 4'h0, 4'd7,  32'h0, 1'b0, 4'h0, 4'd0, 32'h0,
               32'h2, 32'h2, 32'h2, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[6]  = '{1'b1, 4'hC, 4'd9,  32'hFFFF0000, 1'b1, 4'hF, 4'd9, 32'h0000FFFF,
               32'hFFFF0000, 32'h0, 32'h2, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[7]  = '{1'b1, 4'h0, 4'd9,  32'h0, 1'b0, 4'h0, 4'd0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[8]  = '{1'b1, 4'hF, 4'd11, 32'h12345678, 1'b1, 4'h0, 4'd11, 32'h0,
               32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h0, 32'h0};
    tv[9]  = '{1'b1, 4'h0, 4'd5,  32'h0, 1'b1, 4'h0, 4'd11, 32'h0,
               32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b1, 32'h12345678, 32'h12345678, 32'h12345678};
    tv[10] = '{1'b1, 4'h0, 4'd13, 32'h0, 1'b1, 4'hF, 4'd13, 32'hCAFEBABE,
               32'h0, 32'h0, 32'h0, 1'b1, 32'hCAFEBABE, 32'h0, 32'h12345678};
    tv[11] = '{1'b1, 4'h0, 4'd13, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0,
               32'hCAFEBABE, 32'hCAFEBABE, 32'hCAFEBABE, 1'b1, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    tv[12] = '{1'b1, 4'h0, 4'd9,  32'h0, 1'b1, 4'h0, 4'd9, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

    rst_n = 1'b0;
    idle();
    @(negedge clk);
    repeat (3) step();
    chk("rst_busy_wf", {31'b0, bz[0]}, 32'h1);
    chk("rst_busy_noclear", {31'b0, bz[3]}, 32'h0);
    chk("rst_dout_a", da[0], 32'h0);
    chk("rst_dout_b_rf", db[1], 32'h0);
    chk("rst_rvalid_a", {31'b0, va[0]}, 32'h0);
    rst_n = 1'b1;
    wait_clear("clear");
    chk("clear_busy_rf", {31'b0, bz[1]}, 32'h0);
    read_all_zero("clear");

    for (int i = 0; i < 13; i++) begin
      en_a = tv[i].en_a; we_a = tv[i].we_a; addr_a = tv[i].addr_a; di_a = tv[i].di_a;
      en_b = tv[i].en_b; we_b = tv[i].we_b; addr_b = tv[i].addr_b; di_b = tv[i].di_b;
      step();
      chk($sformatf("v%0d_wf_a", i), da[0], tv[i].ea_wf);
      chk($sformatf("v%0d_nc_a", i), da[2], tv[i].ea_nc);
      chk($sformatf("v%0d_wf_rva", i), {31'b0, va[0]}, {31'b0, tv[i].en_a});
      chk($sformatf("v%0d_nc_rva", i), {31'b0, va[2]}, {31'b0, tv[i].en_a & ~|tv[i].we_a});
      chk($sformatf("v%0d_nc_rvb", i), {31'b0, vb[2]}, {31'b0, tv[i].en_b & ~|tv[i].we_b});
      if (tv[i].chk_b) begin
        chk($sformatf("v%0d_wf_b", i), db[0], tv[i].eb_wf);
        chk($sformatf("v%0d_nc_b", i), db[2], tv[i].eb_nc);
      end
      idle();
      step();
      chk($sformatf("v%0d_rf_a", i), da[1], tv[i].ea_rf);
      chk($sformatf("v%0d_rf_rva", i), {31'b0, va[1]}, {31'b0, tv[i].en_a});
      chk($sformatf("v%0d_rf_rvb", i), {31'b0, vb[1]}, {31'b0, tv[i].en_b});
      if (tv[i].chk_b) chk($sformatf("v%0d_rf_b", i), db[1], tv[i].eb_rf);
    end

    // Reset in the middle of a clear, with accesses attempted while busy
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (9) step();
    rst_n = 1'b0;
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd0; di_a = 32'hFFFFFFFF;
    en_b = 1'b1; we_b = 4'h0; addr_b = 4'd13;
    step();
    rst_n = 1'b1;
    wait_clear("reclear");
    idle();
    read_all_zero("reclear");

    for (int a = 0; a < 16; a++) mm[a] = 32'h0;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        ed[k][p] = 32'h0; ev[k][p] = 1'b0; s1[k][p] = 32'h0; v1[k][p] = 1'b0;
      end
    for (int c = 0; c < 300; c++) begin
      logic pe [2];
      logic [3:0] pw [2];
      logic [3:0] pa [2];
      logic [31:0] pd [2];
      logic [31:0] old [2];
      logic [31:0] mrg [2];
      en_a = ($urandom_range(0, 3) != 0); we_a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      addr_a = 4'($urandom); di_a = $urandom;
      en_b = ($urandom_range(0, 3) != 0); we_b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      addr_b = 4'($urandom); di_b = $urandom;
      if (en_a && en_b && we_a != 0 && we_b != 0 && addr_a == addr_b) we_b = 4'h0;
      pe[0] = en_a; pw[0] = we_a; pa[0] = addr_a; pd[0] = di_a;
      pe[1] = en_b; pw[1] = we_b; pa[1] = addr_b; pd[1] = di_b;
      for (int p = 0; p < 2; p++) begin
        old[p] = mm[pa[p]];
        mrg[p] = old[p];
        for (int l = 0; l < 4; l++) if (pw[p][l]) mrg[p][8*l+:8] = pd[p][8*l+:8];
      end
      for (int p = 1; p >= 0; p--)
        if (pe[p])
          for (int l = 0; l < 4; l++) if (pw[p][l]) mm[pa[p]][8*l+:8] = pd[p][8*l+:8];
      for (int k = 0; k < 3; k++)
        for (int p = 0; p < 2; p++) begin
          logic acc;
          logic [31:0] val;
          acc = pe[p] && !(mode_of[k] == 2 && pw[p] != 0);
          val = (mode_of[k] == 0 && pw[p] != 0) ? mrg[p] : old[p];
          if (oreg_of[k] == 0) begin
            if (acc) ed[k][p] = val;
            ev[k][p] = acc;
          end else begin
            ed[k][p] = s1[k][p];
            ev[k][p] = v1[k][p];
            if (acc) s1[k][p] = val;
            v1[k][p] = acc;
          end
        end
      step();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_i%0d_da", c, k), da[k], ed[k][0]);
        chk($sformatf("rnd%0d_i%0d_va", c, k), {31'b0, va[k]}, {31'b0, ev[k][0]});
        chk($sformatf("rnd%0d_i%0d_db", c, k), db[k], ed[k][1]);
        chk($sformatf("rnd%0d_i%0d_vb", c, k), {31'b0, vb[k]}, {31'b0, ev[k][1]});
      end
    end

    // Back-to-back reads through the output register
    for (int a = 1; a <= 3; a++) begin
      en_a = 1'b1; we_a = 4'hF; addr_a = 4'(a); di_a = 32'h10101010 * a;
      step();
    end
    idle();
    repeat (2) step();
    for (int a = 1; a <= 5; a++) begin
      en_a = (a <= 3); we_a = 4'h0; addr_a = 4'(a);
      step();
      if (a >= 2 && a <= 4) begin
        chk($sformatf("oreg_d%0d", a), da[1], 32'h10101010 * (a - 1));
        chk($sformatf("oreg_v%0d", a), {31'b0, va[1]}, 32'h1);
      end else begin
        chk($sformatf("oreg_v%0d", a), {31'b0, va[1]}, 32'h0);
      end
    end
    chk("oreg_hold", da[1], 32'h30303030);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
